// File: rtl/icache_miss_unit_if.sv
// Signal bundle between fetch/icache, memory port and the instruction miss unit.
interface icache_miss_unit_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 64,
  parameter int TAG_W      = 4,
  parameter int SLOT_W     = 4
);
  logic [NUM_PORTS-1:0]             miss_valid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] miss_addr;
  logic                             flush;
  logic                             mem_req_valid;
  logic [ADDR_W-1:0]                mem_req_addr;
  logic [TAG_W-1:0]                 mem_tag_ack;
  logic [BLOCK_BITS-1:0]            mem_data;
  logic [TAG_W-1:0]                 mem_data_tag;
  logic                             fill_valid;
  logic [ADDR_W-1:0]                fill_addr;
  logic [BLOCK_BITS-1:0]            fill_data;
  logic [SLOT_W-1:0]                free_slots;

  modport slave (
    input  miss_valid, miss_addr, flush, mem_tag_ack, mem_data, mem_data_tag,
    output mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, free_slots
  );
  modport master (
    output miss_valid, miss_addr, flush, mem_tag_ack, mem_data, mem_data_tag,
    input  mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, free_slots
  );
endinterface

// File: rtl/icache_miss_unit.sv
// Instruction MSHR file with next-line prefetch: merges fetch misses, issues one tagged
// memory request per cycle and hands returned blocks to the icache as a registered fill.
module icache_miss_unit #(
  parameter int NUM_PORTS      = 2,
  parameter int MSHR_DEPTH     = 8,
  parameter int PREFETCH_DEPTH = 2,
  parameter int ADDR_W         = 32,
  parameter int LINE_OFFSET    = 3,
  parameter int BLOCK_BITS     = 64,
  parameter int TAG_W          = 4
) (
  input  logic              clock,
  input  logic              reset,
  icache_miss_unit_if.slave bus
);
  localparam int LW = ADDR_W - LINE_OFFSET;
  localparam int IW = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam int SW = $clog2(MSHR_DEPTH) + 1;

  typedef enum logic [1:0] {INVALID = 2'd0, WAIT_ISSUE = 2'd1, WAIT_DATA = 2'd2} ent_st_e;
  typedef struct packed {
    ent_st_e          st;
    logic [LW-1:0]    line;
    logic             pf;
    logic [TAG_W-1:0] tag;
  } mshr_t;

  mshr_t [MSHR_DEPTH-1:0] ent_q, ent_d;

  logic                  iss_vld, iss_dem, iss_pre, ack;
  logic [IW-1:0]         iss_idx, iss_dem_idx, iss_pre_idx;
  logic                  ret_hit;
  logic [IW-1:0]         ret_idx;
  logic [LW-1:0]         ret_line;
  logic [LW-1:0]         cand, pf_base;
  logic                  cand_hit, slot_ok, pf_go, pf_stop;
  logic [IW-1:0]         slot;
  logic [SW-1:0]         free_cnt;
  logic                  fill_vld_q;
  logic [ADDR_W-1:0]     fill_addr_q;
  logic [BLOCK_BITS-1:0] fill_data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q       <= '0;
      fill_vld_q  <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      ent_q      <= ent_d;
      fill_vld_q <= ret_hit;
      if (ret_hit) begin
        fill_addr_q <= {ret_line, {LINE_OFFSET{1'b0}}};
        fill_data_q <= bus.mem_data;
      end
    end
  end

  // Issue select and free count look only at registered state.
  always_comb begin
    iss_dem     = 1'b0;
    iss_pre     = 1'b0;
    iss_dem_idx = '0;
    iss_pre_idx = '0;
    free_cnt    = '0;
    for (int e = 0; e < MSHR_DEPTH; e++) begin
      if (ent_q[e].st == WAIT_ISSUE && !ent_q[e].pf && !iss_dem) begin
        iss_dem     = 1'b1;
        iss_dem_idx = IW'(e);
      end
      if (ent_q[e].st == WAIT_ISSUE && ent_q[e].pf && !iss_pre) begin
        iss_pre     = 1'b1;
        iss_pre_idx = IW'(e);
      end
      if (ent_q[e].st == INVALID) free_cnt = free_cnt + SW'(1);
    end
    iss_vld = iss_dem | iss_pre;
    iss_idx = iss_dem ? iss_dem_idx : iss_pre_idx;
  end

  always_comb begin
    ent_d   = ent_q;
    ret_hit = 1'b0;
    ret_idx = '0;
    for (int e = 0; e < MSHR_DEPTH; e++)
      if (!ret_hit && bus.mem_data_tag != '0 && ent_q[e].st == WAIT_DATA &&
          ent_q[e].tag == bus.mem_data_tag) begin
        ret_hit = 1'b1;
        ret_idx = IW'(e);
      end
    ret_line = ent_q[ret_idx].line;
    if (ret_hit) ent_d[ret_idx].st = INVALID;

    ack = iss_vld && (bus.mem_tag_ack != '0);
    if (ack) begin
      ent_d[iss_idx].st  = WAIT_DATA;
      ent_d[iss_idx].tag = bus.mem_tag_ack;
    end
    if (bus.flush)
      for (int e = 0; e < MSHR_DEPTH; e++)
        if (ent_d[e].st == WAIT_ISSUE) ent_d[e].st = INVALID;

    // The returning line counts as present even though its slot is already reusable.
    pf_go    = 1'b0;
    pf_base  = '0;
    cand     = '0;
    cand_hit = 1'b0;
    slot_ok  = 1'b0;
    slot     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.miss_valid[p]) begin
        cand     = bus.miss_addr[p][ADDR_W-1:LINE_OFFSET];
        cand_hit = ret_hit && (ret_line == cand);
        for (int e = 0; e < MSHR_DEPTH; e++)
          if (ent_d[e].st != INVALID && ent_d[e].line == cand) begin
            cand_hit = 1'b1;
            if (ent_d[e].st == WAIT_ISSUE) ent_d[e].pf = 1'b0;
          end
        if (!cand_hit) begin
          slot_ok = 1'b0;
          slot    = '0;
          for (int e = 0; e < MSHR_DEPTH; e++)
            if (!slot_ok && ent_d[e].st == INVALID) begin
              slot_ok = 1'b1;
              slot    = IW'(e);
            end
          for (int e = 0; e < MSHR_DEPTH; e++)
            if (!slot_ok && ent_d[e].st == WAIT_ISSUE && ent_d[e].pf) begin
              slot_ok = 1'b1;
              slot    = IW'(e);
            end
          if (slot_ok) begin
            ent_d[slot] = '{st: WAIT_ISSUE, line: cand, pf: 1'b0, tag: '0};
            if (!pf_go) begin
              pf_go   = 1'b1;
              pf_base = cand;
            end
          end
        end
      end
    end

    pf_stop = 1'b0;
    for (int k = 1; k <= PREFETCH_DEPTH; k++) begin
      if (pf_go && !pf_stop) begin
        cand     = pf_base + LW'(k);
        cand_hit = ret_hit && (ret_line == cand);
        for (int e = 0; e < MSHR_DEPTH; e++)
          if (ent_d[e].st != INVALID && ent_d[e].line == cand) cand_hit = 1'b1;
        if (!cand_hit) begin
          slot_ok = 1'b0;
          slot    = '0;
          for (int e = 0; e < MSHR_DEPTH; e++)
            if (!slot_ok && ent_d[e].st == INVALID) begin
              slot_ok = 1'b1;
              slot    = IW'(e);
            end
          if (slot_ok) ent_d[slot] = '{st: WAIT_ISSUE, line: cand, pf: 1'b1, tag: '0};
          else         pf_stop     = 1'b1;
        end
      end
    end
  end

  assign bus.mem_req_valid = iss_vld;
  assign bus.mem_req_addr  = iss_vld ? {ent_q[iss_idx].line, {LINE_OFFSET{1'b0}}} : '0;
  assign bus.fill_valid    = fill_vld_q;
  assign bus.fill_addr     = fill_addr_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.free_slots    = free_cnt;
endmodule

// File: tb/tb_icache_miss_unit.sv
// Directed walk through the miss unit's behaviours, then a randomized run scored against
// a slot-level reference model and an independent memory-side record of granted tags.
module tb_icache_miss_unit;
  localparam int NP = 2, MD = 8, PD = 2, AW = 32, LO = 3, BB = 64, TW = 4, SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  icache_miss_unit_if #(.NUM_PORTS(NP), .ADDR_W(AW), .BLOCK_BITS(BB), .TAG_W(TW), .SLOT_W(SW)) bus ();

  icache_miss_unit #(
    .NUM_PORTS(NP), .MSHR_DEPTH(MD), .PREFETCH_DEPTH(PD), .ADDR_W(AW),
    .LINE_OFFSET(LO), .BLOCK_BITS(BB), .TAG_W(TW)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  // reference model: 0 = invalid, 1 = waiting issue, 2 = waiting data
  int          m_st   [MD];
  logic [28:0] m_line [MD];
  bit          m_dem  [MD];
  logic [3:0]  m_tag  [MD];
  bit          m_ret;
  logic [28:0] m_ret_line;

  logic [3:0]  oq_tag  [$];
  logic [31:0] oq_addr [$];

  bit          exp_fv;
  logic [31:0] exp_fa;
  logic [63:0] exp_fd;
  int          iss, r, k;
  logic [3:0]  t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic miss1(input int p, input logic [31:0] a);
    bus.miss_valid    = '0;
    bus.miss_valid[p] = 1'b1;
    bus.miss_addr[p]  = a;
  endtask

  task automatic req_ack(input string nm, input logic [31:0] a, input logic [3:0] tg);
    chk({nm, "_valid"}, bus.mem_req_valid, 1);
    chk({nm, "_addr"}, bus.mem_req_addr, a);
    bus.mem_tag_ack = tg;
    cyc();
    bus.mem_tag_ack = '0;
    bus.miss_valid  = '0;
  endtask

  task automatic ret(input logic [3:0] tg, input logic [63:0] d);
    bus.mem_data_tag = tg;
    bus.mem_data     = d;
    cyc();
    bus.mem_data_tag = '0;
  endtask

  function automatic int m_issue();
    for (int e = 0; e < MD; e++) if (m_st[e] == 1 && m_dem[e]) return e;
    for (int e = 0; e < MD; e++) if (m_st[e] == 1) return e;
    return -1;
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int e = 0; e < MD; e++) if (m_st[e] == 0) n++;
    return n;
  endfunction

  function automatic bit m_present(input logic [28:0] x);
    if (m_ret && m_ret_line == x) return 1'b1;
    for (int e = 0; e < MD; e++) if (m_st[e] != 0 && m_line[e] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_slot(input bit may_replace);
    for (int e = 0; e < MD; e++) if (m_st[e] == 0) return e;
    if (may_replace) for (int e = 0; e < MD; e++) if (m_st[e] == 1 && !m_dem[e]) return e;
    return -1;
  endfunction

  task automatic m_step(input int is);
    int s;
    bit trig;
    logic [28:0] base, x;
    m_ret = 1'b0;
    if (bus.mem_data_tag != 0)
      for (int e = 0; e < MD; e++)
        if (!m_ret && m_st[e] == 2 && m_tag[e] == bus.mem_data_tag) begin
          m_ret = 1'b1; m_ret_line = m_line[e]; m_st[e] = 0;
        end
    if (is >= 0 && bus.mem_tag_ack != 0) begin m_st[is] = 2; m_tag[is] = bus.mem_tag_ack; end
    if (bus.flush) for (int e = 0; e < MD; e++) if (m_st[e] == 1) m_st[e] = 0;
    trig = 1'b0;
    base = '0;
    for (int p = 0; p < NP; p++) begin
      if (bus.miss_valid[p]) begin
        x = bus.miss_addr[p][31:3];
        if (m_present(x)) begin
          for (int e = 0; e < MD; e++) if (m_st[e] == 1 && m_line[e] == x) m_dem[e] = 1'b1;
        end else begin
          s = m_slot(1'b1);
          if (s >= 0) begin
            m_st[s] = 1; m_line[s] = x; m_dem[s] = 1'b1;
            if (!trig) begin trig = 1'b1; base = x; end
          end
        end
      end
    end
    if (trig)
      for (int j = 1; j <= PD; j++) begin
        x = base + 29'(j);
        if (!m_present(x)) begin
          s = m_slot(1'b0);
          if (s < 0) break;
          m_st[s] = 1; m_line[s] = x; m_dem[s] = 1'b0;
        end
      end
  endtask

  function automatic logic [31:0] rnd_addr();
    int rr = $urandom_range(0, 19);
    logic [28:0] l;
    l = (rr < 16) ? 29'(rr) : 29'h1FFF_FFFC + 29'(rr - 16);
    return {l, 3'($urandom_range(0, 7))};
  endfunction

  function automatic logic [3:0] free_tag();
    int s = $urandom_range(0, 14);
    logic [3:0] c;
    bit used;
    for (int i = 0; i < 15; i++) begin
      c = 4'(((s + i) % 15) + 1);
      used = 1'b0;
      foreach (oq_tag[q]) if (oq_tag[q] == c) used = 1'b1;
      if (!used) return c;
    end
    return 4'd0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.miss_valid   = 2'b11;
    bus.miss_addr[0] = 32'h100;
    bus.miss_addr[1] = 32'h200;
    bus.flush        = 1'b0;
    bus.mem_tag_ack  = '0;
    bus.mem_data     = '0;
    bus.mem_data_tag = '0;
    repeat (3) cyc();
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_addr", bus.fill_addr, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    chk("rst_free", bus.free_slots, 8);
    bus.miss_valid = '0;
    rst_n = 1'b1;
    chk("rst_release_idle", bus.mem_req_valid, 0);

    // demand miss with two sequential prefetches
    miss1(0, 32'h100); cyc(); bus.miss_valid = '0;
    chk("t1_free", bus.free_slots, 5);
    req_ack("t1_req0", 32'h100, 4'd1);
    req_ack("t1_req1", 32'h108, 4'd2);
    req_ack("t1_req2", 32'h110, 4'd3);
    chk("t1_idle", bus.mem_req_valid, 0);
    ret(4'd2, 64'h0123_4567_89AB_CDEF);
    chk("t1_fill_valid", bus.fill_valid, 1);
    chk("t1_fill_addr", bus.fill_addr, 32'h108);
    chk("t1_fill_data", bus.fill_data, 64'h0123_4567_89AB_CDEF);
    chk("t1_free_after_ret", bus.free_slots, 6);
    cyc();
    chk("t1_fill_one_cycle", bus.fill_valid, 0);
    ret(4'd1, 64'h11);
    chk("t1_fill_addr_tag1", bus.fill_addr, 32'h100);
    ret(4'd3, 64'h33);
    chk("t1_free_end", bus.free_slots, 8);

    // same-cycle merge, then upgrade of a waiting prefetch
    bus.miss_valid = 2'b11; bus.miss_addr[0] = 32'h200; bus.miss_addr[1] = 32'h204;
    cyc(); bus.miss_valid = '0;
    chk("t2_merge_free", bus.free_slots, 5);
    chk("t2_req_addr", bus.mem_req_addr, 32'h200);
    miss1(1, 32'h210); cyc(); bus.miss_valid = '0;
    chk("t2_upgrade_no_alloc", bus.free_slots, 5);
    req_ack("t2_req0", 32'h200, 4'd4);
    req_ack("t2_upgraded_first", 32'h210, 4'd5);
    req_ack("t2_req2", 32'h208, 4'd6);
    chk("t2_idle", bus.mem_req_valid, 0);
    ret(4'd4, 64'h4); ret(4'd5, 64'h5); ret(4'd6, 64'h6);
    chk("t2_free_end", bus.free_slots, 8);

    // rejected requests are held and retried
    miss1(0, 32'h300); cyc(); bus.miss_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_retry_addr", bus.mem_req_addr, 32'h300);
      cyc();
    end
    req_ack("t3_accept", 32'h300, 4'd7);
    chk("t3_next_pf", bus.mem_req_addr, 32'h308);
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk("t3_flush_free", bus.free_slots, 7);
    chk("t3_flush_idle", bus.mem_req_valid, 0);
    ret(4'd7, 64'h77);
    chk("t3_fill_valid", bus.fill_valid, 1);
    chk("t3_fill_addr", bus.fill_addr, 32'h300);
    chk("t3_free_end", bus.free_slots, 8);

    // full file: demand miss replaces the lowest waiting prefetch
    miss1(0, 32'h1000); cyc(); bus.miss_valid = '0;
    miss1(0, 32'h2000); req_ack("t4_a", 32'h1000, 4'd1);
    miss1(0, 32'h3000); req_ack("t4_b", 32'h2000, 4'd2);
    req_ack("t4_c", 32'h3000, 4'd3);
    req_ack("t4_d", 32'h1008, 4'd4);
    req_ack("t4_e", 32'h1010, 4'd5);
    req_ack("t4_f", 32'h2008, 4'd6);
    chk("t4_full", bus.free_slots, 0);
    chk("t4_pf_pending", bus.mem_req_addr, 32'h2010);
    miss1(0, 32'h400); cyc(); bus.miss_valid = '0;
    chk("t4_full_after_repl", bus.free_slots, 0);
    req_ack("t4_repl_issue", 32'h400, 4'd7);
    chk("t4_other_pf_kept", bus.mem_req_addr, 32'h3008);
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    for (int i = 1; i <= 7; i++) ret(4'(i), 64'(i));
    chk("t4_free_end", bus.free_slots, 8);

    // prefetch wraps past the top of the address space; flush spares WAIT_DATA
    miss1(0, 32'hFFFF_FFF8); cyc(); bus.miss_valid = '0;
    chk("t5_free", bus.free_slots, 5);
    req_ack("t5_top", 32'hFFFF_FFF8, 4'd9);
    req_ack("t5_wrap0", 32'h0, 4'd10);
    chk("t5_wrap8", bus.mem_req_addr, 32'h8);
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk("t5_flush_free", bus.free_slots, 6);
    chk("t5_flush_idle", bus.mem_req_valid, 0);
    ret(4'd9, 64'h99);
    chk("t5_fill_valid", bus.fill_valid, 1);
    chk("t5_fill_addr", bus.fill_addr, 32'hFFFF_FFF8);
    ret(4'd10, 64'hAA);
    chk("t5_fill_addr_wrap", bus.fill_addr, 32'h0);
    chk("t5_free_end", bus.free_slots, 8);

    // reset mid-operation discards entries and ignores late data
    miss1(0, 32'h600); cyc(); bus.miss_valid = '0;
    req_ack("t6_req", 32'h600, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", bus.mem_req_valid, 0);
    chk("t6_async_free", bus.free_slots, 8);
    cyc();
    rst_n = 1'b1;
    ret(4'd5, 64'h55);
    chk("t6_stale_no_fill", bus.fill_valid, 0);
    chk("t6_free", bus.free_slots, 8);

    // randomized traffic against the model
    exp_fv = 1'b0;
    for (int cy = 0; cy < 500; cy++) begin
      iss = m_issue();
      chk("rnd_req_valid", bus.mem_req_valid, (iss >= 0) ? 1 : 0);
      if (iss >= 0) chk("rnd_req_addr", bus.mem_req_addr, {m_line[iss], 3'b000});
      chk("rnd_free", bus.free_slots, m_free());
      chk("rnd_fill_valid", bus.fill_valid, exp_fv);
      if (exp_fv) begin
        chk("rnd_fill_addr", bus.fill_addr, exp_fa);
        chk("rnd_fill_data", bus.fill_data, exp_fd);
      end

      bus.miss_valid = '0;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 99) < 40) begin
          bus.miss_valid[p] = 1'b1;
          bus.miss_addr[p]  = rnd_addr();
        end
      bus.flush        = ($urandom_range(0, 99) < 5);
      bus.mem_data     = {$urandom, $urandom};
      bus.mem_data_tag = '0;
      exp_fv = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 30 && oq_tag.size() > 0) begin
        k = $urandom_range(0, oq_tag.size() - 1);
        bus.mem_data_tag = oq_tag[k];
        exp_fv = 1'b1;
        exp_fa = oq_addr[k];
        exp_fd = bus.mem_data;
        oq_tag.delete(k);
        oq_addr.delete(k);
      end else if (r < 36) begin
        bus.mem_data_tag = free_tag();
      end
      bus.mem_tag_ack = '0;
      if (iss >= 0 && $urandom_range(0, 99) < 60) begin
        t = free_tag();
        bus.mem_tag_ack = t;
        oq_tag.push_back(t);
        oq_addr.push_back({m_line[iss], 3'b000});
      end
      m_step(iss);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
